pe_ram_loader: RTL and testbench

- Parametrised DMA-style loader that copies a programmable-length block from external RAM into the PE-local RAMs.
- Sits between the host interface and the N_PE PE memories.
- Successor to the single-shot copy controller. Adds:
  - transfer length
  - destination base address
  - per-PE write mask
  - broadcast and scatter modes
  - parametrised read latency
  - busy/done status

---
 rtl/pe_ram_loader.sv | 170 +++++++++++++++++
 tb/tb_pe_ram_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ram_loader.sv
// pe_ram_loader: copies a block of xfer_len words from external RAM into the
// N_PE PE-local RAMs. Reads stream at one word per cycle. Each returned word
// is either broadcast to every enabled PE at dst+i, or scattered round-robin
// (word i goes to PE i mod N_PE at dst + i/N_PE).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   host_start          single-cycle start request (sampled only in IDLE)
//   ext_start_addr, dst_start_addr, xfer_len, mode, pe_mask
//                       transfer descriptor, latched on an accepted start
//   ext_r_en/_addr      external RAM read port
//   ext_r_data          read data, valid RD_LAT cycles after ext_r_en
//   mem_w_en/_addr/_data  registered PE RAM write port (addr/data shared)
//   busy, done          status: busy during READ/DRAIN, done pulses one cycle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for host_start
// READ  | issuing one external read per cycle until xfer_len reads issued
// DRAIN | reads finished, waiting for the in-flight words to be written
// DONE  | one-cycle completion pulse, then back to IDLE
module pe_ram_loader #(
  parameter int N_PE     = 8,
  parameter int ADDR_EXT = 16,
  parameter int ADDR_RAM = 10,
  parameter int WID_RAM  = 16,
  parameter int LEN_W    = 16,
  parameter int RD_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_start,
  input  logic [ADDR_EXT-1:0] ext_start_addr,
  input  logic [ADDR_RAM-1:0] dst_start_addr,
  input  logic [LEN_W-1:0]    xfer_len,
  input  logic                mode,
  input  logic [N_PE-1:0]     pe_mask,
  output logic                ext_r_en,
  output logic [ADDR_EXT-1:0] ext_r_addr,
  input  logic [WID_RAM-1:0]  ext_r_data,
  output logic [N_PE-1:0]     mem_w_en,
  output logic [ADDR_RAM-1:0] mem_w_addr,
  output logic [WID_RAM-1:0]  mem_w_data,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int KW = (N_PE > 1) ? $clog2(N_PE) : 1;

  logic [1:0]          state_q, state_d;
  logic [ADDR_EXT-1:0] src_q, src_d;
  logic [ADDR_RAM-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]    rd_rem_q, rd_rem_d;
  logic [LEN_W-1:0]    wr_rem_q, wr_rem_d;
  logic                mode_q, mode_d;
  logic [N_PE-1:0]     mask_q, mask_d;
  logic [KW-1:0]       k_q, k_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [N_PE-1:0]     mem_w_en_q, mem_w_en_d;
  logic [ADDR_RAM-1:0] mem_w_addr_q, mem_w_addr_d;
  logic [WID_RAM-1:0]  mem_w_data_q, mem_w_data_d;
  logic [N_PE-1:0]     sel_oh;

  assign ext_r_en   = (state_q == S_READ);
  assign ext_r_addr = src_q;
  assign busy       = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign mem_w_en   = mem_w_en_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_w_data = mem_w_data_q;

  assign sel_oh = N_PE'(1) << k_q;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    waddr_d      = waddr_q;
    rd_rem_d     = rd_rem_q;
    wr_rem_d     = wr_rem_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    k_d          = k_q;
    mem_w_en_d   = '0;
    mem_w_addr_d = mem_w_addr_q;
    mem_w_data_d = mem_w_data_q;

    // vld_q[n] marks a read issued n+1 cycles ago; the top bit lines up
    // with ext_r_data for that read.
    vld_d    = '0;
    vld_d[0] = ext_r_en;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

    case (state_q)
      S_IDLE: begin
        if (host_start) begin
          src_d    = ext_start_addr;
          waddr_d  = dst_start_addr;
          rd_rem_d = xfer_len;
          wr_rem_d = xfer_len;
          mode_d   = mode;
          mask_d   = pe_mask;
          k_d      = '0;
          state_d  = (xfer_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        src_d    = src_q + 1'b1;
        rd_rem_d = rd_rem_q - 1'b1;
        if (rd_rem_q == LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_rem_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A returning word always consumes a slot, even when its PE is masked
    // off, so the scatter index and row stay aligned with the word index.
    if (vld_q[RD_LAT-1]) begin
      mem_w_en_d   = mode_q ? (sel_oh & mask_q) : mask_q;
      mem_w_addr_d = waddr_q;
      mem_w_data_d = ext_r_data;
      wr_rem_d     = wr_rem_q - 1'b1;
      if (!mode_q) begin
        waddr_d = waddr_q + 1'b1;
      end else if (k_q == KW'(N_PE - 1)) begin
        k_d     = '0;
        waddr_d = waddr_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      waddr_q      <= '0;
      rd_rem_q     <= '0;
      wr_rem_q     <= '0;
      mode_q       <= 1'b0;
      mask_q       <= '0;
      k_q          <= '0;
      vld_q        <= '0;
      mem_w_en_q   <= '0;
      mem_w_addr_q <= '0;
      mem_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      waddr_q      <= waddr_d;
      rd_rem_q     <= rd_rem_d;
      wr_rem_q     <= wr_rem_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      k_q          <= k_d;
      vld_q        <= vld_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_data_q <= mem_w_data_d;
    end
  end

endmodule

// File: tb/tb_pe_ram_loader.sv
// Directed bench for pe_ram_loader. Three instances (RD_LAT = 2, 1, 4) share
// the same stimulus; each has its own external RAM model with RAM[a] = a.
module tb_pe_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_start;
  logic [15:0] ext_start_addr;
  logic [9:0]  dst_start_addr;
  logic [15:0] xfer_len;
  logic        mode;
  logic [7:0]  pe_mask;

  logic        ren   [3];
  logic [15:0] raddr [3];
  logic [15:0] rdata [3];
  logic [7:0]  wen   [3];
  logic [9:0]  waddr [3];
  logic [15:0] wdata [3];
  logic        busy_o[3];
  logic        done_o[3];

  logic [15:0] pipe [3][4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_ram_loader #(.RD_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .host_start(host_start),
    .ext_start_addr(ext_start_addr), .dst_start_addr(dst_start_addr),
    .xfer_len(xfer_len), .mode(mode), .pe_mask(pe_mask),
    .ext_r_en(ren[0]), .ext_r_addr(raddr[0]), .ext_r_data(rdata[0]),
    .mem_w_en(wen[0]), .mem_w_addr(waddr[0]), .mem_w_data(wdata[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  pe_ram_loader #(.RD_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .host_start(host_start),
    .ext_start_addr(ext_start_addr), .dst_start_addr(dst_start_addr),
    .xfer_len(xfer_len), .mode(mode), .pe_mask(pe_mask),
    .ext_r_en(ren[1]), .ext_r_addr(raddr[1]), .ext_r_data(rdata[1]),
    .mem_w_en(wen[1]), .mem_w_addr(waddr[1]), .mem_w_data(wdata[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  pe_ram_loader #(.RD_LAT(4)) u_l4 (
    .clk(clk), .rst(rst), .host_start(host_start),
    .ext_start_addr(ext_start_addr), .dst_start_addr(dst_start_addr),
    .xfer_len(xfer_len), .mode(mode), .pe_mask(pe_mask),
    .ext_r_en(ren[2]), .ext_r_addr(raddr[2]), .ext_r_data(rdata[2]),
    .mem_w_en(wen[2]), .mem_w_addr(waddr[2]), .mem_w_data(wdata[2]),
    .busy(busy_o[2]), .done(done_o[2]));

  // External RAM models: data for a read issued in cycle C is presented
  // during cycle C+lat; non-read slots carry a poison value.
  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      for (int k = 3; k > 0; k--) pipe[j][k] <= pipe[j][k-1];
      pipe[j][0] <= ren[j] ? raddr[j] : 16'hDEAD;
    end
  end

  assign rdata[0] = pipe[0][1];
  assign rdata[1] = pipe[1][0];
  assign rdata[2] = pipe[2][3];

  task automatic chk(input string tag, input int j, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, j, $time, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk({tag, "_ren"},  j, 32'(ren[j]),    32'd0);
      chk({tag, "_wen"},  j, 32'(wen[j]),    32'd0);
      chk({tag, "_busy"}, j, 32'(busy_o[j]), 32'd0);
      chk({tag, "_done"}, j, 32'(done_o[j]), 32'd0);
    end
  endtask

  // Starts a transfer and checks every output of all three instances cycle
  // by cycle. restart_at > 0 pulses a second (to be ignored) start with a
  // different descriptor in that cycle.
  task automatic run_xfer(input string tag, input logic [15:0] ext,
                          input logic [9:0] dst, input int len, input logic md,
                          input logic [7:0] mask, input int restart_at);
    int          lat, i, li;
    logic        e_ren, e_busy, e_done, e_wv;
    logic [15:0] e_raddr, e_wdata, l_wdata;
    logic [9:0]  e_waddr, l_waddr;
    logic [7:0]  e_wen;

    @(negedge clk);
    chk({tag, "_idle_busy"}, 0, 32'(busy_o[0]), 32'd0);
    host_start     = 1'b1;
    ext_start_addr = ext;
    dst_start_addr = dst;
    xfer_len       = 16'(len);
    mode           = md;
    pe_mask        = mask;

    for (int c = 1; c <= len + 8; c++) begin
      @(negedge clk);
      host_start = (c == restart_at);
      if (c == restart_at) begin
        ext_start_addr = 16'h5555;
        dst_start_addr = 10'h155;
        xfer_len       = 16'd2;
        mode           = ~md;
        pe_mask        = 8'h01;
      end
      for (int j = 0; j < 3; j++) begin
        lat     = (j == 0) ? 2 : (j == 1) ? 1 : 4;
        e_ren   = (len != 0) && (c <= len);
        e_raddr = ext + 16'(c - 1);
        e_busy  = (len != 0) && (c <= len + lat + 1);
        e_done  = (len == 0) ? (c == 1) : (c == len + lat + 2);
        i       = c - lat - 2;
        e_wv    = (i >= 0) && (i < len);
        e_wen   = 8'd0;
        e_waddr = dst + 10'(md ? i / 8 : i);
        e_wdata = ext + 16'(i);
        if (e_wv) e_wen = md ? ((8'd1 << (i % 8)) & mask) : mask;
        li      = len - 1;
        l_waddr = dst + 10'(md ? li / 8 : li);
        l_wdata = ext + 16'(li);

        chk({tag, "_ren"},  j, 32'(ren[j]),    32'(e_ren));
        if (e_ren) chk({tag, "_raddr"}, j, 32'(raddr[j]), 32'(e_raddr));
        chk({tag, "_busy"}, j, 32'(busy_o[j]), 32'(e_busy));
        chk({tag, "_done"}, j, 32'(done_o[j]), 32'(e_done));
        chk({tag, "_wen"},  j, 32'(wen[j]),    32'(e_wen));
        if (e_wv) begin
          chk({tag, "_waddr"}, j, 32'(waddr[j]), 32'(e_waddr));
          chk({tag, "_wdata"}, j, 32'(wdata[j]), 32'(e_wdata));
        end else if (len > 0 && i >= len) begin
          chk({tag, "_waddr_hold"}, j, 32'(waddr[j]), 32'(l_waddr));
          chk({tag, "_wdata_hold"}, j, 32'(wdata[j]), 32'(l_wdata));
        end
      end
    end
    host_start = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    host_start     = 1'b0;
    ext_start_addr = '0;
    dst_start_addr = '0;
    xfer_len       = '0;
    mode           = 1'b0;
    pe_mask        = '0;
    repeat (3) @(negedge clk);

    for (int j = 0; j < 3; j++) begin
      chk("rst_ren",   j, 32'(ren[j]),    32'd0);
      chk("rst_raddr", j, 32'(raddr[j]),  32'd0);
      chk("rst_wen",   j, 32'(wen[j]),    32'd0);
      chk("rst_waddr", j, 32'(waddr[j]),  32'd0);
      chk("rst_wdata", j, 32'(wdata[j]),  32'd0);
      chk("rst_busy",  j, 32'(busy_o[j]), 32'd0);
      chk("rst_done",  j, 32'(done_o[j]), 32'd0);
    end
    rst = 1'b0;

    run_xfer("bcast",   16'h0100, 10'h010, 4,  1'b0, 8'hFF, 0);
    run_xfer("scatter", 16'h0000, 10'h000, 10, 1'b1, 8'hFB, 0);
    run_xfer("zero",    16'h1234, 10'h020, 0,  1'b0, 8'hFF, 0);
    run_xfer("wrap",    16'hFFFE, 10'h3FF, 3,  1'b0, 8'hFF, 0);
    run_xfer("restart", 16'h0200, 10'h040, 5,  1'b0, 8'h3C, 2);

    // Reset after two reads: everything goes quiet, no writes, no done.
    @(negedge clk);
    host_start     = 1'b1;
    ext_start_addr = 16'h0400;
    dst_start_addr = 10'h100;
    xfer_len       = 16'd6;
    mode           = 1'b0;
    pe_mask        = 8'hFF;
    @(negedge clk);
    host_start = 1'b0;
    chk("midrst_ren1",   0, 32'(ren[0]),   32'd1);
    chk("midrst_raddr1", 0, 32'(raddr[0]), 32'h0400);
    @(negedge clk);
    chk("midrst_raddr2", 0, 32'(raddr[0]), 32'h0401);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("midrst_raddr", j, 32'(raddr[j]), 32'd0);
      chk("midrst_waddr", j, 32'(waddr[j]), 32'd0);
      chk("midrst_wdata", j, 32'(wdata[j]), 32'd0);
    end
    for (int c = 0; c < 9; c++) begin
      chk_quiet("midrst");
      @(negedge clk);
    end

    // Reset and start in the same cycle: reset wins.
    rst        = 1'b1;
    host_start = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    host_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_quiet("rst_start");
      @(negedge clk);
    end

    run_xfer("fresh", 16'h0300, 10'h080, 6, 1'b1, 8'hFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
